// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: the decode-side handshake and the instruction-memory read port.
// The master modport is the fetch stage; the slave modport is decode plus memory.
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        instr_valid;

    modport master (
        input  stall, redirect, redirect_pc, imem_ready, imem_rdata,
        output imem_req, imem_addr, instr_out, instr_pc, instr_pc4, instr_valid
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ready, imem_rdata,
        input  imem_req, imem_addr, instr_out, instr_pc, instr_pc4, instr_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem read in flight and hands
// one instruction per handshake to decode, with a one-entry skid for stalled responses.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input logic           CLOCK,
    input logic           RESET_N,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_FULL} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] out_q, out_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        valid_q, valid_d;
    logic        discard_q, discard_d;
    logic        req;
    logic        free;

    assign free = !valid_q || !bus.stall;

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path can infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        out_d       = out_q;
        ipc_d       = ipc_q;
        ipc4_d      = ipc4_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        valid_d     = valid_q;
        discard_d   = discard_q;
        req         = 1'b0;

        // Decode took the current word; later assignments win if a new one lands.
        if (valid_q && !bus.stall) begin
            valid_d = 1'b0;
            out_d   = NOP_WORD;
        end

        if (bus.redirect) begin
            pc_d    = bus.redirect_pc & ~32'd3;
            valid_d = 1'b0;
            out_d   = NOP_WORD;
            state_d = S_ISSUE;
            if (state_q == S_WAIT && !bus.imem_ready) begin
                discard_d = 1'b1;
                state_d   = S_WAIT;
            end else if (state_q == S_WAIT) begin
                discard_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                S_ISSUE: begin
                    if (free) begin
                        req     = 1'b1;
                        addr_d  = pc_q;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_ready) begin
                        state_d = S_ISSUE;
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else if (free) begin
                            out_d   = bus.imem_rdata;
                            ipc_d   = pc_q;
                            ipc4_d  = pc_q + 32'd4;
                            valid_d = 1'b1;
                            pc_d    = pc_q + 32'd4;
                        end else begin
                            skid_data_d = bus.imem_rdata;
                            skid_pc_d   = pc_q;
                            pc_d        = pc_q + 32'd4;
                            state_d     = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (!bus.stall) begin
                        out_d   = skid_data_q;
                        ipc_d   = skid_pc_q;
                        ipc4_d  = skid_pc_q + 32'd4;
                        valid_d = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
                default: state_d = S_ISSUE;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_ISSUE;
            pc_q        <= RESET_PC & ~32'd3;
            addr_q      <= RESET_PC & ~32'd3;
            out_q       <= NOP_WORD;
            ipc_q       <= 32'd0;
            ipc4_q      <= 32'd0;
            skid_data_q <= 32'd0;
            skid_pc_q   <= 32'd0;
            valid_q     <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            out_q       <= out_d;
            ipc_q       <= ipc_d;
            ipc4_q      <= ipc4_d;
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
            valid_q     <= valid_d;
            discard_q   <= discard_d;
        end
    end

    // The address follows pc while issuing and is frozen while the read is in flight.
    assign bus.imem_req    = req && RESET_N;
    assign bus.imem_addr   = (state_q == S_ISSUE) ? pc_q : addr_q;
    assign bus.instr_out   = out_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.instr_pc4   = ipc4_q;
    assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed steps for reset, stall, redirect and PC wrap, then a
// random phase checked against an instruction-stream model (program order from each redirect).
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0020;

    logic CLOCK   = 1'b0;
    logic RESET_N = 1'b1;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
        .CLOCK  (CLOCK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int          total      = 0;
    int          bad        = 0;
    int          lat        = 1;
    int          handshakes = 0;
    logic [31:0] data_key   = 32'd0;
    logic [31:0] exp_pc     = 32'd0;
    logic        mon_on     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive point: just after the rising edge. Sample point: the falling edge.
    task automatic cyc();
        @(posedge CLOCK);
        #2;
    endtask

    task automatic neg();
        @(negedge CLOCK);
    endtask

    // Memory: one response per request, 'lat' cycles later, data = address ^ data_key.
    logic        pending = 1'b0;
    int          cnt     = 0;
    logic [31:0] paddr   = 32'd0;

    initial begin
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'd0;
        forever begin
            @(negedge CLOCK);
            if (RESET_N && bus.imem_req) begin
                check_bit("one_outstanding", pending, 1'b0);
                check("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
                pending = 1'b1;
                cnt     = lat;
                paddr   = bus.imem_addr;
            end
            @(posedge CLOCK);
            #1;
            bus.imem_ready = 1'b0;
            if (!RESET_N) begin
                pending = 1'b0;
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    bus.imem_ready = 1'b1;
                    bus.imem_rdata = paddr ^ data_key;
                    pending        = 1'b0;
                end
            end
        end
    end

    // Stream model: every word decode takes must be the next word in program order.
    initial begin
        forever begin
            @(negedge CLOCK);
            if (mon_on) begin
                if (bus.instr_valid && !bus.stall) begin
                    check("stream_pc", bus.instr_pc, exp_pc);
                    check("stream_data", bus.instr_out, exp_pc ^ data_key);
                    check("stream_pc4", bus.instr_pc4, exp_pc + 32'd4);
                    exp_pc += 32'd4;
                    handshakes++;
                end
                if (!bus.instr_valid) check("idle_nop", bus.instr_out, NOP);
                if (bus.redirect) begin
                    check_bit("no_req_on_redirect", bus.imem_req, 1'b0);
                    exp_pc = bus.redirect_pc & ~32'd3;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;

        // Reset values, applied without a clock edge.
        #1 RESET_N = 1'b0;
        #1;
        check_bit("rst_valid", bus.instr_valid, 1'b0);
        check("rst_out", bus.instr_out, NOP);
        check("rst_pc", bus.instr_pc, 32'd0);
        check("rst_pc4", bus.instr_pc4, 32'd0);
        check_bit("rst_req", bus.imem_req, 1'b0);
        check("rst_addr", bus.imem_addr, RST_PC);
        cyc();
        cyc();
        RESET_N = 1'b1;
        neg();
        check_bit("first_req", bus.imem_req, 1'b1);
        check("first_addr", bus.imem_addr, RST_PC);
        cyc();
        neg();
        check_bit("wait_no_req", bus.imem_req, 1'b0);
        check_bit("wait_valid", bus.instr_valid, 1'b0);

        // Streaming with 1-cycle memory: one instruction every two cycles.
        for (int i = 0; i < 3; i++) begin
            cyc();
            neg();
            check_bit("seq_valid", bus.instr_valid, 1'b1);
            check("seq_out", bus.instr_out, RST_PC + 32'(4 * i));
            check("seq_pc", bus.instr_pc, RST_PC + 32'(4 * i));
            check("seq_pc4", bus.instr_pc4, RST_PC + 32'(4 * i + 4));
            check_bit("seq_req", bus.imem_req, 1'b1);
            check("seq_addr", bus.imem_addr, RST_PC + 32'(4 * i + 4));
            cyc();
            neg();
            check_bit("seq_gap_valid", bus.instr_valid, 1'b0);
            check("seq_gap_out", bus.instr_out, NOP);
            check_bit("seq_gap_req", bus.imem_req, 1'b0);
        end

        // Stall holds the valid word and blocks further requests.
        cyc();
        bus.stall = 1'b1;
        neg();
        for (int i = 0; i < 5; i++) begin
            check_bit("stall_valid", bus.instr_valid, 1'b1);
            check("stall_out", bus.instr_out, RST_PC + 32'd12);
            check_bit("stall_no_req", bus.imem_req, 1'b0);
            cyc();
            neg();
        end
        check("stall_hold_out", bus.instr_out, RST_PC + 32'd12);
        cyc();
        bus.stall = 1'b0;
        neg();
        check_bit("unstall_req", bus.imem_req, 1'b1);
        check("unstall_addr", bus.imem_addr, RST_PC + 32'd16);
        check("unstall_out", bus.instr_out, RST_PC + 32'd12);
        cyc();
        lat = 3;
        neg();
        check_bit("unstall_gap_valid", bus.instr_valid, 1'b0);
        cyc();
        neg();
        check("unstall_next_out", bus.instr_out, RST_PC + 32'd16);
        check("slow_req_addr", bus.imem_addr, RST_PC + 32'd20);

        // Redirect while waiting on a 3-cycle read: the stale response is dropped.
        cyc();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_1003;
        neg();
        check_bit("redir_no_req", bus.imem_req, 1'b0);
        check_bit("redir_valid", bus.instr_valid, 1'b0);
        cyc();
        bus.redirect = 1'b0;
        neg();
        check_bit("discard_wait_req", bus.imem_req, 1'b0);
        check("discard_addr_held", bus.imem_addr, RST_PC + 32'd20);
        cyc();
        lat = 1;
        neg();
        check_bit("stale_dropped_valid", bus.instr_valid, 1'b0);
        check("stale_dropped_out", bus.instr_out, NOP);
        check_bit("stale_no_req", bus.imem_req, 1'b0);
        cyc();
        neg();
        check_bit("redir_req", bus.imem_req, 1'b1);
        check("redir_addr", bus.imem_addr, 32'h0000_1000);

        // Redirect in the same cycle as the response, with decode stalled.
        cyc();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_2000;
        bus.stall       = 1'b1;
        neg();
        check_bit("redir_ready_no_req", bus.imem_req, 1'b0);
        cyc();
        bus.redirect = 1'b0;
        neg();
        check_bit("redir_ready_valid", bus.instr_valid, 1'b0);
        check("redir_ready_out", bus.instr_out, NOP);
        check_bit("redir_ready_req", bus.imem_req, 1'b1);
        check("redir_ready_addr", bus.imem_addr, 32'h0000_2000);
        cyc();
        bus.stall = 1'b0;
        neg();
        cyc();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        neg();
        check("target_out", bus.instr_out, 32'h0000_2000);
        check("target_pc", bus.instr_pc, 32'h0000_2000);
        check_bit("target_redir_no_req", bus.imem_req, 1'b0);

        // PC wrap at the top of the address space.
        cyc();
        bus.redirect = 1'b0;
        neg();
        check_bit("wrap_req", bus.imem_req, 1'b1);
        check("wrap_req_addr", bus.imem_addr, 32'hFFFF_FFFC);
        cyc();
        neg();
        cyc();
        neg();
        check("wrap_out", bus.instr_out, 32'hFFFF_FFFC);
        check("wrap_pc", bus.instr_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", bus.instr_pc4, 32'h0000_0000);
        check("wrap_next_addr", bus.imem_addr, 32'h0000_0000);

        // Asynchronous reset between edges while a stalled word is held.
        cyc();
        bus.stall = 1'b1;
        neg();
        cyc();
        neg();
        check_bit("held_valid", bus.instr_valid, 1'b1);
        check("held_pc", bus.instr_pc, 32'h0000_0000);
        #1 RESET_N = 1'b0;
        data_key = $urandom | 32'h0001_0000;
        #1;
        check_bit("arst_valid", bus.instr_valid, 1'b0);
        check("arst_out", bus.instr_out, NOP);
        check("arst_pc", bus.instr_pc, 32'd0);
        check("arst_pc4", bus.instr_pc4, 32'd0);
        check_bit("arst_req", bus.imem_req, 1'b0);
        check("arst_addr", bus.imem_addr, RST_PC);
        cyc();
        cyc();
        bus.stall = 1'b0;
        RESET_N   = 1'b1;
        exp_pc    = RST_PC;
        mon_on    = 1'b1;
        neg();
        check_bit("rerst_req", bus.imem_req, 1'b1);
        check("rerst_addr", bus.imem_addr, RST_PC);

        // Random stall/redirect/latency traffic against the stream model.
        for (int i = 0; i < 600; i++) begin
            cyc();
            bus.stall       = ($urandom_range(0, 2) == 0);
            bus.redirect    = ($urandom_range(0, 15) == 0);
            bus.redirect_pc = $urandom;
            lat             = $urandom_range(1, 3);
        end
        cyc();
        bus.stall    = 1'b0;
        bus.redirect = 1'b0;
        mon_on       = 1'b0;
        check_bit("progress", handshakes >= 60, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
